// File: rtl/ray_core_dispatcher.sv
// Purpose: raster-order pixel scheduler that shares one frame among NUM_CORES ray cores, round-robin, then flips the buffer.
// Latency: frame_start 1 cycle after the vsync start condition; first strobe 1 cycle after frame_start; frame_done 1 cycle after the last core_done.
// Backpressure: a core is eligible only while it has no pixel outstanding; with no eligible core the pixel counter holds and nothing is strobed.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   enable                 allows new frames to start (sampled in IDLE / WAIT_VSYNC only)
//   vsync                  active-low vertical blank; low lets a frame start
//   core_done[i]           one-cycle pulse: core i finished its pixel
//   core_strobe[i]         one-cycle pulse: core i takes the pixel on slice i of core_x/core_y
//   core_x, core_y         per-core coordinates, slice i = [i*COORD_W +: COORD_W], held until the next strobe to core i
//   frame_start/frame_done one-cycle frame boundary pulses
//   frame_flip             buffer-select level, toggles once per completed frame
//   busy                   high while dispatching or draining
module ray_core_dispatcher #(
    parameter int NUM_CORES = 4,
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 240,
    parameter int COORD_W   = 11
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         enable,
    input  logic                         vsync,
    input  logic [NUM_CORES-1:0]         core_done,
    output logic [NUM_CORES-1:0]         core_strobe,
    output logic [NUM_CORES*COORD_W-1:0] core_x,
    output logic [NUM_CORES*COORD_W-1:0] core_y,
    output logic                         frame_start,
    output logic                         frame_done,
    output logic                         frame_flip,
    output logic                         busy
);
    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [PW-1:0]      LAST_CORE = PW'(NUM_CORES - 1);
    localparam logic [PW:0]        NCORES    = (PW + 1)'(NUM_CORES);
    localparam logic [COORD_W-1:0] LAST_X    = COORD_W'(FB_WIDTH - 1);
    localparam logic [COORD_W-1:0] LAST_Y    = COORD_W'(FB_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_VSYNC, DISPATCH, DRAIN} state_t;

    state_t               state;
    logic [NUM_CORES-1:0] outstanding;
    logic [NUM_CORES-1:0] grant_mask;
    logic [NUM_CORES-1:0] out_next;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        grant_idx;
    logic [PW-1:0]        cand_idx;
    logic [PW:0]          cand_sum;
    logic                 grant_vld;
    logic [COORD_W-1:0]   cnt_x;
    logic [COORD_W-1:0]   cnt_y;

    // Round-robin search from ptr. Walking the offsets from the far end
    // down lets the nearest eligible core overwrite any farther one.
    // Eligibility uses the registered flags only, so a core whose done
    // arrives this cycle is not re-granted until the next one.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand_sum  = '0;
        cand_idx  = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            cand_sum = {1'b0, ptr} + (PW + 1)'(k);
            cand_idx = (cand_sum >= NCORES) ? PW'(cand_sum - NCORES) : cand_sum[PW-1:0];
            if (!outstanding[cand_idx]) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    assign grant_mask = (state == DISPATCH && grant_vld) ? (NUM_CORES'(1) << grant_idx) : '0;
    // A done on a core that is not outstanding simply clears an already clear bit.
    assign out_next   = (outstanding & ~core_done) | grant_mask;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            outstanding <= '0;
            ptr         <= '0;
            cnt_x       <= '0;
            cnt_y       <= '0;
            core_strobe <= '0;
            core_x      <= '0;
            core_y      <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_flip  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            core_strobe <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            outstanding <= out_next;
            case (state)
                IDLE: begin
                    if (enable) state <= WAIT_VSYNC;
                end
                WAIT_VSYNC: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (!vsync && outstanding == '0) begin
                        state       <= DISPATCH;
                        frame_start <= 1'b1;
                        busy        <= 1'b1;
                        cnt_x       <= '0;
                        cnt_y       <= '0;
                        ptr         <= '0;
                    end
                end
                DISPATCH: begin
                    if (grant_vld) begin
                        core_strobe                           <= grant_mask;
                        core_x[grant_idx*COORD_W +: COORD_W] <= cnt_x;
                        core_y[grant_idx*COORD_W +: COORD_W] <= cnt_y;
                        ptr <= (grant_idx == LAST_CORE) ? '0 : grant_idx + 1'b1;
                        if (cnt_x == LAST_X) begin
                            cnt_x <= '0;
                            if (cnt_y == LAST_Y) begin
                                cnt_y <= '0;
                                state <= DRAIN;
                            end else begin
                                cnt_y <= cnt_y + 1'b1;
                            end
                        end else begin
                            cnt_x <= cnt_x + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Looking at out_next lets frame_done land one cycle after the last done.
                    if (out_next == '0) begin
                        frame_done <= 1'b1;
                        frame_flip <= ~frame_flip;
                        busy       <= 1'b0;
                        state      <= WAIT_VSYNC;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ray_core_dispatcher.md
# ray_core_dispatcher

Frame-level pixel scheduler that shares the screen among `NUM_CORES` ray cores. It waits for vertical blank, walks the framebuffer in raster order and hands one pixel per cycle to a free core using round-robin selection. After the last pixel it waits for every core to finish, then flips the frame buffer. It sits between the render-state/VSync logic and the `RayCore` array, replacing per-core ad-hoc strobing.

## Interface
- `NUM_CORES`, 4, number of ray cores served (2..8)
- `FB_WIDTH`, 320, pixels per line
- `FB_HEIGHT`, 240, lines per frame
- `COORD_W`, 11, coordinate width (matches screen-coordinate width)

- `clk`  in  1  single clock for the whole block
- `resetn`  in  1  reset, asynchronous, active-low
- `enable`  in  1  allow frames to start
- `vsync`  in  1  active-low vertical blank; low = frame may start
- `core_done`  in  NUM_CORES  one-cycle pulse per core: pixel finished
- `core_strobe`  out  NUM_CORES  one-cycle pulse: core i accepts pixel on `core_x`/`core_y` slice i
- `core_x`  out  NUM_CORES*COORD_W  per-core pixel x, slice i = bits [i*COORD_W +: COORD_W]
- `core_y`  out  NUM_CORES*COORD_W  per-core pixel y, same slicing
- `frame_start`  out  1  one-cycle pulse at start of frame
- `frame_done`  out  1  one-cycle pulse when all pixels of the frame have completed
- `frame_flip`  out  1  buffer-select level, toggles once per completed frame
- `busy`  out  1  high in DISPATCH and DRAIN

## Operation
- States: IDLE, WAIT_VSYNC, DISPATCH, DRAIN.
- IDLE:
  - `enable`=1 -> WAIT_VSYNC.
- WAIT_VSYNC:
  - `enable`=0 -> IDLE.
  - `vsync`=0 and no core outstanding -> DISPATCH.
  - On that transition: `frame_start`=1, pixel counter = (0,0), round-robin pointer = 0.
- DISPATCH, per cycle:
  - Eligible core = outstanding flag clear (registered value).
  - Grant the first eligible core at or after the pointer, modulo `NUM_CORES`.
  - On grant: strobe the core, load its x/y slice with the counter, set its outstanding flag, pointer = granted+1 mod N, advance the counter.
  - No eligible core: no strobe, counter holds.
- Counter: x increments; at x=`FB_WIDTH`-1, x wraps to 0 and y increments.
- Granting (`FB_WIDTH`-1, `FB_HEIGHT`-1) -> DRAIN.
- DRAIN: no strobes. When all outstanding flags are clear -> `frame_done`=1, `frame_flip` toggles, go to WAIT_VSYNC.
- Because of the DRAIN exit, the next frame needs `vsync` low again. If `vsync` is still low, it restarts immediately, matching free-running render.
- Outstanding flag:
  - Set by the strobe.
  - Cleared by that core's `core_done`.
  - `core_done` on a non-outstanding core is ignored.
  - A core cleared at cycle t is eligible again at t+1, never in the same cycle.
- `enable` is sampled only in IDLE and WAIT_VSYNC. Dropping it mid-frame lets the frame complete, then the block returns to IDLE.
- `core_x`/`core_y` slice i holds its value from strobe until the next strobe to core i.
- Counter widths are `COORD_W`. No arithmetic overflow is possible when `FB_WIDTH`, `FB_HEIGHT` < 2^`COORD_W`.

## Timing
- Reset (async assert, sync release): state IDLE, all outputs 0, all outstanding flags 0, counter (0,0), pointer 0, `frame_flip`=0.
- All outputs are registered.
- WAIT_VSYNC with start condition at cycle T: `frame_start`=1 and `busy`=1 at T+1. First `core_strobe` no earlier than T+2; `frame_start` never coincides with a strobe.
- Throughput: at most one strobe per cycle; one strobe every cycle while any core is eligible.
- Core re-use: strobe at t, done at d -> next strobe to that core at ≥ d+1.
- Last `core_done` at cycle d in DRAIN -> `frame_done` pulse and `frame_flip` toggle at d+1, `busy`=0 at d+1.
- Reset mid-frame: immediate return to reset values. Pending cores' later `core_done` pulses are ignored.

## Test plan
- Reset:
  - Stimulus: `resetn` low with random inputs.
  - Required: all outputs 0, IDLE. `enable`=1, `vsync`=1 for 10 cycles -> no `frame_start`.
- Full frame, with `NUM_CORES`=4, `FB_WIDTH`=4, `FB_HEIGHT`=2, each core done 3 cycles after strobe, `vsync`=0:
  - Exactly 8 strobes, core order 0,1,2,3,0,1,2,3, coords (0,0),(1,0),(2,0),(3,0),(0,1)…(3,1).
  - One `frame_done`; `frame_flip` goes 0->1.
- Stalled core, same config, core 2 withholds done for 20 cycles:
  - Dispatch skips core 2 and continues on 0,1,3.
  - DRAIN holds `busy`=1 until core 2 is done; `frame_done` arrives exactly 1 cycle later.
- Stray done and re-grant timing:
  - `core_done`[1] pulsed while core 1 is idle -> no state change.
  - Done and grant never target the same core in the same cycle.
- Enable drop:
  - `enable`->0 mid-DISPATCH -> frame completes with all 8 pixels, `frame_flip` toggles, then IDLE; no new `frame_start`.
- Reset mid-frame:
  - `resetn` pulse after 3 strobes -> outputs cleared immediately.
  - Late `core_done` pulses are ignored.
  - After `resetn` release with `enable`=1, `vsync`=0: new frame starts at (0,0), core 0.
